// File: rtl/sseg_disp_arbiter.sv
// sseg_disp_arbiter: shares the 4-digit seven-segment display between two
// requesters. Round-robin grant with a minimum hold time (value stays
// readable) and a maximum hold time (no starvation). Idle shows DEFAULT_VAL.
module sseg_disp_arbiter #(
    parameter int unsigned MIN_TICKS   = 2,
    parameter int unsigned MAX_TICKS   = 8,
    parameter logic [15:0] DEFAULT_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3
);

    localparam int unsigned CW = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_TICKS);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_TICKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic          last;
    logic [15:0]   disp;

    logic          own_req;
    logic          oth_req;
    logic [15:0]   own_data;
    logic [15:0]   oth_data;
    logic          hand_off;

    assign digit3 = disp[15:12];
    assign digit2 = disp[11:8];
    assign digit1 = disp[7:4];
    assign digit0 = disp[3:0];

    // Resolve "owner" vs "other" so both OWN states share one decision path
    always_comb begin
        own_req  = req0;
        oth_req  = req1;
        own_data = data0;
        oth_data = data1;
        if (state == OWN1) begin
            own_req  = req1;
            oth_req  = req0;
            own_data = data1;
            oth_data = data0;
        end
        hand_off = (state != IDLE) &&
                   ((!own_req && (tick_cnt >= MIN_C)) ||
                    (own_req && oth_req && (tick_cnt >= MAX_C)));
    end

    // Grant FSM with registered grants, busy flag and display value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            disp     <= DEFAULT_VAL;
            tick_cnt <= '0;
            last     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (req0 && (!req1 || last)) begin
                        state <= OWN0;
                        gnt0  <= 1'b1;
                        gnt1  <= 1'b0;
                        busy  <= 1'b1;
                        disp  <= data0;
                    end else if (req1) begin
                        state <= OWN1;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b1;
                        busy  <= 1'b1;
                        disp  <= data1;
                    end else begin
                        disp  <= DEFAULT_VAL;
                    end
                end
                OWN0, OWN1: begin
                    if (hand_off) begin
                        last     <= (state == OWN1);
                        tick_cnt <= '0;
                        if (oth_req) begin
                            // Direct swap: no idle gap, tick on this edge is not counted
                            state <= (state == OWN0) ? OWN1 : OWN0;
                            gnt0  <= (state == OWN1);
                            gnt1  <= (state == OWN0);
                            busy  <= 1'b1;
                            disp  <= oth_data;
                        end else begin
                            state <= IDLE;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                            busy  <= 1'b0;
                            disp  <= DEFAULT_VAL;
                        end
                    end else begin
                        if (own_req) begin
                            disp <= own_data;
                        end
                        if (tick && (tick_cnt != MAX_C)) begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    busy     <= 1'b0;
                    disp     <= DEFAULT_VAL;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_disp_arbiter.sv
// Directed bench for sseg_disp_arbiter (MIN_TICKS=2, MAX_TICKS=4).
module tb_sseg_disp_arbiter;

    localparam logic [15:0] DEF = 16'hDEF0;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        req0;
    logic [15:0] data0;
    logic        req1;
    logic [15:0] data1;
    logic        gnt0;
    logic        gnt1;
    logic        busy;
    logic [3:0]  digit0;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;

    int errors = 0;
    int checks = 0;

    sseg_disp_arbiter #(
        .MIN_TICKS  (2),
        .MAX_TICKS  (4),
        .DEFAULT_VAL(DEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .req0  (req0),
        .data0 (data0),
        .req1  (req1),
        .data1 (data1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .digit0(digit0),
        .digit1(digit1),
        .digit2(digit2),
        .digit3(digit3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare grants/busy {gnt1,gnt0,busy} and packed digits
    task automatic chk_out(input string tag, input logic [2:0] g, input logic [15:0] d);
        chk({tag, "_gnt"}, {29'd0, gnt1, gnt0, busy}, {29'd0, g});
        chk({tag, "_dig"}, {16'd0, digit3, digit2, digit1, digit0}, {16'd0, d});
    endtask

    initial begin
        rst_n = 1'b0;
        tick  = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 16'h0000;
        data1 = 16'h0000;

        // 1: reset state
        cyc(2);
        chk_out("rst", 3'b000, DEF);
        rst_n = 1'b1;
        cyc(1);
        chk_out("idle", 3'b000, DEF);

        // 2: single grant, 3 ticks, release on first edge with req0 low
        req0 = 1'b1; data0 = 16'h1234;
        cyc(1);
        chk_out("t2_grant", 3'b011, 16'h1234);
        repeat (3) begin
            tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
        end
        chk_out("t2_hold", 3'b011, 16'h1234);
        req0 = 1'b0;
        cyc(1);
        chk_out("t2_release", 3'b000, DEF);

        // 3: one-cycle pulse, held until MIN_TICKS, value frozen
        req0 = 1'b1; data0 = 16'hABCD;
        cyc(1);
        chk_out("t3_grant", 3'b011, 16'hABCD);
        req0 = 1'b0; data0 = 16'h1111;
        cyc(1);
        chk_out("t3_freeze", 3'b011, 16'hABCD);
        tick = 1'b1; cyc(1); tick = 1'b0;
        chk_out("t3_tick1", 3'b011, 16'hABCD);
        cyc(1);
        chk_out("t3_after1", 3'b011, 16'hABCD);
        tick = 1'b1; cyc(1); tick = 1'b0;
        chk_out("t3_tick2", 3'b011, 16'hABCD);
        cyc(1);
        chk_out("t3_idle", 3'b000, DEF);

        // 4: simultaneous requests after reset, source 0 first, seamless swap
        rst_n = 1'b0; #1; rst_n = 1'b1;
        cyc(1);
        req0 = 1'b1; data0 = 16'h1234;
        req1 = 1'b1; data1 = 16'h5678;
        cyc(1);
        chk_out("t4_gnt0", 3'b011, 16'h1234);
        repeat (2) begin
            tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
        end
        chk_out("t4_hold", 3'b011, 16'h1234);
        req0 = 1'b0;
        cyc(1);
        chk_out("t4_swap", 3'b101, 16'h5678);

        // async reset while OWN1
        rst_n = 1'b0; #1;
        chk_out("t4_arst", 3'b000, DEF);
        rst_n = 1'b1; req1 = 1'b0;
        cyc(1);

        // 5: pre-emption at MAX_TICKS and alternation
        req0 = 1'b1; data0 = 16'h0A0A;
        cyc(1);
        chk_out("t5_gnt0", 3'b011, 16'h0A0A);
        req1 = 1'b1; data1 = 16'h5678;
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; cyc(1); tick = 1'b0;
            chk_out("t5_own0", 3'b011, 16'h0A0A);
            cyc(1);
        end
        chk_out("t5_pre1", 3'b101, 16'h5678);
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; cyc(1); tick = 1'b0;
            chk_out("t5_own1", 3'b101, 16'h5678);
            cyc(1);
        end
        chk_out("t5_pre0", 3'b011, 16'h0A0A);

        // 1b: async reset mid-OWN0, no clock edge needed
        rst_n = 1'b0; #1;
        chk_out("t1_arst_own0", 3'b000, DEF);
        rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
        cyc(1);
        chk_out("t1_post", 3'b000, DEF);

        // 6: lone requester, never pre-empted, tracks data with 1-cycle latency
        req1 = 1'b1; data1 = 16'h0001;
        cyc(1);
        chk_out("t6_gnt1", 3'b101, 16'h0001);
        for (int i = 0; i < 20; i++) begin
            data1 = 16'(i * 16'h1111 + 16'h0102);
            tick = 1'b1; cyc(1); tick = 1'b0;
            chk_out("t6_track", 3'b101, 16'(i * 16'h1111 + 16'h0102));
            cyc(1);
        end
        req1 = 1'b0;
        cyc(1);
        chk_out("t6_release", 3'b000, DEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
